mips_inst_encoder: RTL and testbench
====================================

# mips_inst_encoder

Boot-time program loader for the single-cycle MIPS32 core: it is the encoding counterpart of the control unit's instruction decoder. It accepts field-level instruction requests over a valid/ready handshake and packs each one into a 32-bit MIPS word. Each word is written into instruction memory at an auto-incrementing word address. The CPU is held in halt until the final instruction is written.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  encoder can accept a request.
- `req_cls`  in  4  instruction class (see Operation).
- `req_rs`, `req_rt`, `req_rd`, `req_shamt`  in  5 each  register and shift fields.
- `req_imm`  in  16  immediate / branch offset.
- `req_target`  in  26  jump target.
- `req_last`  in  1  marks the final instruction of the program.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `cpu_hold`  out  1  keeps the core halted while loading.
- `done`  out  1  load complete.
- `err`  out  1  sticky error flag.
- `wr_count`  out  ADDR_W+1  number of words written.

## Operation
- **Class codes and encodings:**
  - 0 add: R-type, func 0x20.
  - 1 or: R-type, func 0x25.
  - 2 jr: R-type, func 0x08. Only rs is used; rt, rd and shamt are forced to 0.
  - 3 syscall: fixed word 0x0000000C.
  - 4 sw: op 0x2B.
  - 5 addi: op 0x08.
  - 6 lui: op 0x0F, rs forced to 0.
  - 7 beq: op 0x04.
  - 8 j: op 0x02.
  - 9 jal: op 0x03.
  - 10/11/12 sll/srl/sra: only when configured.
  - All other codes are unknown.
- **Word formats:**
  - R-type: {6'h00, rs, rt, rd, shamt, func}. shamt is forced to 0 except for shift classes.
  - I-type: {op, rs, rt, imm}.
  - J-type: {op, target}.
- **FSM states:**
  - IDLE: `req_ready`=1, `cpu_hold`=1. On `req_valid`:
    - Known class: latch the encoded word, go to WRITE.
    - Unknown class: set `err`, discard the request, stay in IDLE.
  - WRITE: `imem_we`=1 for exactly one cycle, with `imem_addr`=ptr. Then ptr and `wr_count` increment.
    - If `req_last` was latched, go to DONE.
    - Else, if ptr was 2^ADDR_W−1, go to FULL.
    - Otherwise return to IDLE.
  - DONE: `done`=1, `cpu_hold`=0, `req_ready`=0. Terminal until `rst`.
  - FULL: `err`=1, `cpu_hold`=1, `req_ready`=0. Terminal until `rst`. ptr never wraps.
- `err` is sticky until `rst`. An unknown class does not block later valid requests.
- `req_*` fields are captured only on the handshake cycle. Inputs may change freely afterwards.

## Timing
- Reset values: state=IDLE, ptr=0, `wr_count`=0, `req_ready`=1, `cpu_hold`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `err`=0.
- Handshake occurs on a cycle where `req_valid`&&`req_ready`. `req_ready` drops the next cycle (the WRITE cycle).
- Latency: the write strobe asserts 1 cycle after the handshake. `wr_count` updates on the following edge.
- Throughput: one instruction per 2 cycles.
- All outputs are registered. `imem_addr` and `imem_wdata` hold their last values outside WRITE.
- `rst` asserted in any state, including mid-WRITE, returns to IDLE on the next edge. Any pending write is dropped, and `cpu_hold` re-asserts.
- `req_valid` while `req_ready`=0 is ignored. No request is queued.
- An unknown class in the same request as `req_last`: `err` is set, no write occurs, and the FSM stays in IDLE (it does not go to DONE).

## Configuration
- `ENC_SHIFT_EN` defined: classes 10/11/12 encode sll/srl/sra as R-type.
  - func is 0x00/0x02/0x03 respectively.
  - rs is forced to 0, and shamt is taken from `req_shamt`.
- `ENC_SHIFT_EN` undefined: classes 10–12 are treated as unknown (set `err`, no write).

## Test plan
- After `rst`, send add with rs=1, rt=2, rd=3 -> one `imem_we` pulse, `imem_addr`=0, `imem_wdata`=0x00221820, `wr_count`=1.
- Send the sequence:
  - addi rt=1, imm=5 -> word 0x20010005 at addr 0.
  - lui rt=1, imm=0x1234 -> 0x3C011234 at addr 1.
  - sw rs=1, rt=2, imm=8 -> 0xAC220008 at addr 2.
  - j target=0x100 with `req_last`=1 -> 0x08000100 at addr 3.
  - Then `done`=1, `cpu_hold`=0, `req_ready`=0.
- Send class 15, then a valid syscall -> `err`=1 with no write for class 15. Then 0x0000000C is written at addr 0, and `err` stays 1.
- With ADDR_W=2, send 4 non-last requests -> writes to addrs 0..3, then FULL: `err`=1, `req_ready`=0, `cpu_hold`=1, `wr_count`=4.
- Assert `rst` during the WRITE cycle of the second request -> no further writes, and next cycle shows the IDLE reset values (`wr_count`=0, ptr=0).
- With `ENC_SHIFT_EN`, send sll rt=1, rd=2, shamt=4 -> 0x00011100. Without `ENC_SHIFT_EN`, the same request -> `err`=1 and no write.

Source files
------------

// File: rtl/mips_inst_encoder.sv
// Boot-time program loader: packs field-level MIPS32 instruction requests into words
// and writes them to instruction memory. Optional shift classes enabled by ENC_SHIFT_EN.
module mips_inst_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cls,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_FULL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic [32:0]         enc;

    // Returns {known, word}; known=0 marks an unsupported class.
    function automatic logic [32:0] encode(
        input logic [3:0]  cls,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [32:0] r;
        logic        keep_sh;
        r       = '0;
        keep_sh = 1'b0;
        case (cls)
            4'd0: r = {1'b1, 6'h00, rs, rt, rd, (keep_sh ? sh : 5'd0), 6'h20};
            4'd1: r = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd2: r = {1'b1, 6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
            4'd3: r = {1'b1, 32'h0000_000C};
            4'd4: r = {1'b1, 6'h2B, rs, rt, imm};
            4'd5: r = {1'b1, 6'h08, rs, rt, imm};
            4'd6: r = {1'b1, 6'h0F, 5'd0, rt, imm};
            4'd7: r = {1'b1, 6'h04, rs, rt, imm};
            4'd8: r = {1'b1, 6'h02, tgt};
            4'd9: r = {1'b1, 6'h03, tgt};
`ifdef ENC_SHIFT_EN
            4'd10: r = {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h00};
            4'd11: r = {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h02};
            4'd12: r = {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h03};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign enc = encode(req_cls, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (enc[32]) begin
                        wdata_d = enc[31:0];
                        addr_d  = ptr_q;
                        last_d  = req_last;
                        we_d    = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                // The pointer saturates at the top of memory rather than wrapping.
                if (ptr_q != {ADDR_W{1'b1}}) ptr_d = ptr_q + 1'b1;
                if (last_q)                         state_d = S_DONE;
                else if (ptr_q == {ADDR_W{1'b1}})   state_d = S_FULL;
                else                                state_d = S_IDLE;
            end
            default: state_d = state_q;
        endcase
        ready_d = (state_d == S_IDLE);
        hold_d  = (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        if (state_d == S_FULL) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign req_ready  = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign wr_count   = cnt_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Scoreboard bench for mips_inst_encoder: driver pushes expected writes from an
// arithmetic reference model, a negedge monitor pops and compares each imem write.
module tb_mips_inst_encoder;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_cls;
    logic [4:0]    req_rs, req_rt, req_rd, req_shamt;
    logic [15:0]   req_imm;
    logic [25:0]   req_target;
    logic          req_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, done, err;
    logic [AW:0]   wr_count;

    always #5 clk = ~clk;

    mips_inst_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cls(req_cls),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
        .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .wr_count(wr_count)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: 0 loading, 1 done, 2 full
    int  m_ptr, m_cnt, m_state;
    bit  m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint rtype(int rs, int rt, int rd, int sh, int fn);
        return longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
             + longint'(sh) * 64 + longint'(fn);
    endfunction

    function automatic longint itype(int op, int rs, int rt, int imm);
        return longint'(op) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    endfunction

    function automatic longint jtype(int op, int tgt);
        return longint'(op) * 67108864 + longint'(tgt);
    endfunction

    // Returns -1 for classes the encoder must reject.
    function automatic longint ref_word(int cls, int rs, int rt, int rd, int sh, int imm, int tgt);
        case (cls)
            0: return rtype(rs, rt, rd, 0, 32);
            1: return rtype(rs, rt, rd, 0, 37);
            2: return rtype(rs, 0, 0, 0, 8);
            3: return 12;
            4: return itype(43, rs, rt, imm);
            5: return itype(8, rs, rt, imm);
            6: return itype(15, 0, rt, imm);
            7: return itype(4, rs, rt, imm);
            8: return jtype(2, tgt);
            9: return jtype(3, tgt);
`ifdef ENC_SHIFT_EN
            10: return rtype(0, rt, rd, sh, 0);
            11: return rtype(0, rt, rd, sh, 2);
            12: return rtype(0, rt, rd, sh, 3);
`endif
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_state = 0; m_err = 0;
    endtask

    task automatic scramble();
        req_cls    = 4'($urandom);
        req_rs     = 5'($urandom);
        req_rt     = 5'($urandom);
        req_rd     = 5'($urandom);
        req_shamt  = 5'($urandom);
        req_imm    = 16'($urandom);
        req_target = 26'($urandom);
        req_last   = 1'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(int cls, int rs, int rt, int rd, int sh, int imm, int tgt, bit last);
        longint w;
        wr_t    e;
        int     waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (req_ready !== 1'b1) begin
            chk("ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid  = 1'b1;
        req_cls    = 4'(cls);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_shamt  = 5'(sh);
        req_imm    = 16'(imm);
        req_target = 26'(tgt);
        req_last   = last;
        w = ref_word(cls, rs, rt, rd, sh, imm, tgt);
        if (w >= 0) begin
            e.addr = AW'(m_ptr);
            e.data = w[31:0];
            exp_q.push_back(e);
            m_cnt++;
            if (last)                       m_state = 1;
            else if (m_ptr == (1 << AW) - 1) m_state = 2;
            else                            m_ptr++;
        end else begin
            m_err = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble();
        chk("ready_after_hs", 64'(req_ready), (w >= 0) ? 64'd0 : 64'd1);
    endtask

    task automatic settle_and_check();
        repeat (3) @(posedge clk);
        #1;
        chk("wr_count",  64'(wr_count),  64'(m_cnt));
        chk("err",       64'(err),       64'(m_err || m_state == 2));
        chk("done",      64'(done),      64'(m_state == 1));
        chk("cpu_hold",  64'(cpu_hold),  64'(m_state != 1));
        chk("req_ready", 64'(req_ready), 64'(m_state == 0));
        chk("idle_we",   64'(imem_we),   64'd0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst === 1'b0 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e.addr));
                chk("wr_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        scramble();
        model_reset();
        do_reset();

        chk("rst_ready",  64'(req_ready),  64'd1);
        chk("rst_hold",   64'(cpu_hold),   64'd1);
        chk("rst_we",     64'(imem_we),    64'd0);
        chk("rst_addr",   64'(imem_addr),  64'd0);
        chk("rst_wdata",  64'(imem_wdata), 64'd0);
        chk("rst_done",   64'(done),       64'd0);
        chk("rst_err",    64'(err),        64'd0);
        chk("rst_count",  64'(wr_count),   64'd0);

        // single add
        send(0, 1, 2, 3, 0, 0, 0, 1'b0);
        settle_and_check();

        // small program ending in j with last
        do_reset();
        send(5, 0, 1, 0, 0, 5, 0, 1'b0);
        send(6, 7, 1, 0, 0, 'h1234, 0, 1'b0);
        send(4, 1, 2, 0, 0, 8, 0, 1'b0);
        send(8, 0, 0, 0, 0, 0, 'h100, 1'b1);
        settle_and_check();

        // unknown class then syscall
        do_reset();
        send(15, 3, 3, 3, 3, 3, 3, 1'b0);
        send(3, 9, 9, 9, 9, 9, 9, 1'b0);
        settle_and_check();

        // unknown class carrying last must not finish the load
        do_reset();
        send(14, 1, 1, 1, 1, 1, 1, 1'b1);
        settle_and_check();

        // fill memory without last
        do_reset();
        for (int i = 0; i < (1 << AW); i++) send(1, i, i + 1, i + 2, 0, 0, 0, 1'b0);
        settle_and_check();

        // reset during the second write
        do_reset();
        send(0, 1, 2, 3, 0, 0, 0, 1'b0);
        send(1, 4, 5, 6, 0, 0, 0, 1'b0);
        rst = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("midrst_count", 64'(wr_count),   64'd0);
        chk("midrst_addr",  64'(imem_addr),  64'd0);
        chk("midrst_wdata", 64'(imem_wdata), 64'd0);
        chk("midrst_we",    64'(imem_we),    64'd0);
        chk("midrst_ready", 64'(req_ready),  64'd1);
        chk("midrst_hold",  64'(cpu_hold),   64'd1);
        settle_and_check();

        // sll (written only when shift classes are configured)
        do_reset();
        send(10, 0, 1, 2, 4, 0, 0, 1'b0);
        settle_and_check();

        // randomized programs
        for (int r = 0; r < 30; r++) begin
            do_reset();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                if (m_state != 0) break;
                send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
                     int'($urandom_range(0, (1 << 26) - 1)), ($urandom_range(0, 3) == 0));
            end
            settle_and_check();
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
